// File: rtl/saturn_nibble_bus_ctrl.sv
// Saturn nibble-serial bus master: PC streaming, command/address/DP-burst sequencing, core stall.
// Define SATURN_BUS_TRACE_EN to print one simulation trace line per strobe.
module saturn_nibble_bus_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_phase,
  input  logic        i_stalled,
  input  logic        i_alu_busy,
  output logic        o_stall_alu,
  output logic        o_bus_done,
  output logic        o_bus_reset,
  input  logic [3:0]  i_bus_data,
  output logic [3:0]  o_bus_data,
  output logic        o_bus_strobe,
  output logic        o_bus_cmd_data,
  input  logic [19:0] i_address,
  input  logic        i_cmd_load_pc,
  input  logic        i_cmd_load_dp,
  input  logic        i_cmd_config,
  input  logic        i_cmd_reset,
  input  logic        i_cmd_dp_read,
  input  logic        i_cmd_dp_write,
  input  logic [3:0]  i_xfr_cnt,
  output logic [3:0]  o_data_ptr,
  input  logic [3:0]  i_nibble,
  output logic [3:0]  o_nibble
);

  localparam logic [1:0] PH_SEND = 2'd0;
  localparam logic [1:0] PH_RECV = 2'd1;
  localparam logic [1:0] PH_ECMD = 2'd3;

  localparam logic [3:0] CMD_PC_READ  = 4'h0;
  localparam logic [3:0] CMD_DP_READ  = 4'h1;
  localparam logic [3:0] CMD_DP_WRITE = 4'h3;
  localparam logic [3:0] CMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] CMD_LOAD_DP  = 4'h5;
  localparam logic [3:0] CMD_CONFIG   = 4'h6;
  localparam logic [3:0] CMD_RESET    = 4'hA;

  typedef enum logic [2:0] {
    ST_RESUME,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_XFR
  } state_t;

  state_t     state_q;
  logic [3:0] cmd_q;
  logic [3:0] cnt_q;
  logic [3:0] ptr_q;
  logic [2:0] idx_q;
  logic       fetch_q;
  logic       strobe_q;
  logic       cmd_data_q;
  logic [3:0] bus_data_q;
  logic [3:0] nibble_q;
  logic       done_q;
  logic       stall_q;
  logic       bus_reset_q;

  logic       req_vld_d;
  logic [3:0] req_code_d;

  always_comb begin
    req_vld_d  = 1'b1;
    req_code_d = CMD_PC_READ;
    if (i_cmd_reset)         req_code_d = CMD_RESET;
    else if (i_cmd_config)   req_code_d = CMD_CONFIG;
    else if (i_cmd_load_pc)  req_code_d = CMD_LOAD_PC;
    else if (i_cmd_load_dp)  req_code_d = CMD_LOAD_DP;
    else if (i_cmd_dp_read)  req_code_d = CMD_DP_READ;
    else if (i_cmd_dp_write) req_code_d = CMD_DP_WRITE;
    else                     req_vld_d  = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_RESUME;
      cmd_q       <= CMD_PC_READ;
      cnt_q       <= 4'd0;
      ptr_q       <= 4'd0;
      idx_q       <= 3'd0;
      fetch_q     <= 1'b0;
      strobe_q    <= 1'b0;
      cmd_data_q  <= 1'b0;
      bus_data_q  <= 4'd0;
      nibble_q    <= 4'd0;
      done_q      <= 1'b0;
      stall_q     <= 1'b1;
      bus_reset_q <= 1'b1;
    end else if (i_stalled) begin
      // Pulses drop so that nothing repeats when the freeze lifts.
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (i_phase)
        PH_SEND: begin
          case (state_q)
            ST_RESUME: begin
              strobe_q   <= 1'b1;
              cmd_data_q <= 1'b1;
              bus_data_q <= CMD_PC_READ;
            end
            ST_IDLE: begin
              fetch_q    <= !i_alu_busy;
              strobe_q   <= !i_alu_busy;
              cmd_data_q <= 1'b0;
            end
            ST_CMD: begin
              strobe_q   <= 1'b1;
              cmd_data_q <= 1'b1;
              bus_data_q <= cmd_q;
            end
            ST_ADDR: begin
              strobe_q   <= 1'b1;
              cmd_data_q <= 1'b0;
              bus_data_q <= i_address[{idx_q, 2'b00} +: 4];
            end
            ST_XFR: begin
              strobe_q   <= 1'b1;
              cmd_data_q <= 1'b0;
              if (cmd_q == CMD_DP_WRITE) bus_data_q <= i_nibble;
            end
            default: ;
          endcase
        end
        PH_RECV: begin
          if ((state_q == ST_IDLE && fetch_q) || (state_q == ST_XFR && cmd_q == CMD_DP_READ))
            nibble_q <= i_bus_data;
        end
        PH_ECMD: begin
          bus_reset_q <= 1'b0;
          case (state_q)
            ST_RESUME: begin
              state_q <= ST_IDLE;
              stall_q <= 1'b0;
            end
            ST_IDLE: begin
              if (req_vld_d) begin
                state_q <= ST_CMD;
                cmd_q   <= req_code_d;
                cnt_q   <= i_xfr_cnt;
                stall_q <= 1'b1;
              end
            end
            ST_CMD: begin
              idx_q <= 3'd0;
              ptr_q <= 4'd0;
              if (cmd_q == CMD_RESET) begin
                state_q <= ST_RESUME;
                done_q  <= 1'b1;
              end else if (cmd_q == CMD_DP_READ || cmd_q == CMD_DP_WRITE) begin
                state_q <= ST_XFR;
              end else begin
                state_q <= ST_ADDR;
              end
            end
            ST_ADDR: begin
              if (idx_q == 3'd4) begin
                state_q <= ST_RESUME;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
            ST_XFR: begin
              if (ptr_q == cnt_q) begin
                state_q <= ST_RESUME;
                done_q  <= 1'b1;
              end else begin
                ptr_q <= ptr_q + 4'd1;
              end
            end
            default: state_q <= ST_RESUME;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_bus_strobe   = strobe_q & ~i_stalled;
  assign o_bus_cmd_data = cmd_data_q;
  assign o_bus_data     = bus_data_q;
  assign o_nibble       = nibble_q;
  assign o_data_ptr     = ptr_q;
  assign o_bus_done     = done_q;
  assign o_stall_alu    = stall_q;
  assign o_bus_reset    = bus_reset_q;

`ifdef SATURN_BUS_TRACE_EN
  always @(posedge i_clk) begin
    if (o_bus_strobe)
      $display("bus: phase=%0d cmd_data=%b nibble=%h state=%s",
               i_phase, o_bus_cmd_data, o_bus_data, state_q.name());
  end
`else
`endif

endmodule

// File: tb/tb_saturn_nibble_bus_ctrl.sv
// Directed bench for saturn_nibble_bus_ctrl; the bench drives the 4-clock bus phase sequence itself.
module tb_saturn_nibble_bus_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [1:0]  i_phase = 2'd2;
  logic        i_stalled = 1'b0;
  logic        i_alu_busy = 1'b0;
  logic        o_stall_alu, o_bus_done, o_bus_reset, o_bus_strobe, o_bus_cmd_data;
  logic [3:0]  i_bus_data = 4'd0;
  logic [3:0]  o_bus_data, o_data_ptr, o_nibble;
  logic [19:0] i_address = 20'd0;
  logic        i_cmd_load_pc = 1'b0, i_cmd_load_dp = 1'b0, i_cmd_config = 1'b0;
  logic        i_cmd_reset = 1'b0, i_cmd_dp_read = 1'b0, i_cmd_dp_write = 1'b0;
  logic [3:0]  i_xfr_cnt = 4'd0;
  logic [3:0]  i_nibble = 4'd0;

  int checks = 0;
  int errors = 0;

  saturn_nibble_bus_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_phase(i_phase), .i_stalled(i_stalled),
    .i_alu_busy(i_alu_busy), .o_stall_alu(o_stall_alu), .o_bus_done(o_bus_done),
    .o_bus_reset(o_bus_reset), .i_bus_data(i_bus_data), .o_bus_data(o_bus_data),
    .o_bus_strobe(o_bus_strobe), .o_bus_cmd_data(o_bus_cmd_data), .i_address(i_address),
    .i_cmd_load_pc(i_cmd_load_pc), .i_cmd_load_dp(i_cmd_load_dp), .i_cmd_config(i_cmd_config),
    .i_cmd_reset(i_cmd_reset), .i_cmd_dp_read(i_cmd_dp_read), .i_cmd_dp_write(i_cmd_dp_write),
    .i_xfr_cnt(i_xfr_cnt), .o_data_ptr(o_data_ptr), .i_nibble(i_nibble), .o_nibble(o_nibble)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [1:0] ph);
    i_phase = ph;
    @(posedge i_clk);
    #1;
  endtask

  // One full bus cycle; strobe/cmd/data sampled after the SEND edge, done after ECMD.
  task automatic bus_cycle(output logic s, output logic c, output logic [3:0] d, output logic dn);
    tick(2'd0);
    s = o_bus_strobe; c = o_bus_cmd_data; d = o_bus_data;
    tick(2'd1);
    tick(2'd2);
    tick(2'd3);
    dn = o_bus_done;
  endtask

  task automatic test_reset;
    logic s, c, dn;
    logic [3:0] d;
    logic [3:0] rom [3];
    rom[0] = 4'h3; rom[1] = 4'hC; rom[2] = 4'h7;
    #12;
    checks++;
    if ({o_bus_reset, o_bus_data, o_bus_strobe, o_bus_cmd_data, o_stall_alu, o_bus_done, o_data_ptr, o_nibble}
        !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_values: rst=%b data=%h stb=%b cd=%b stall=%b done=%b ptr=%h nib=%h required 1 0 0 0 1 0 0 0",
               o_bus_reset, o_bus_data, o_bus_strobe, o_bus_cmd_data, o_stall_alu, o_bus_done, o_data_ptr, o_nibble);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d, o_bus_reset, o_stall_alu} !== {1'b1, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL resume_cmd: stb=%b cd=%b data=%h rst=%b stall=%b required 1 1 0 0 0", s, c, d, o_bus_reset, o_stall_alu);
    end
    for (int k = 0; k < 3; k++) begin
      i_bus_data = rom[k];
      bus_cycle(s, c, d, dn);
      checks++;
      if ({s, c, o_nibble, o_stall_alu} !== {1'b1, 1'b0, rom[k], 1'b0}) begin
        errors++;
        $display("FAIL pc_stream[%0d]: stb=%b cd=%b nib=%h stall=%b required 1 0 %h 0", k, s, c, o_nibble, o_stall_alu, rom[k]);
      end
    end
  endtask

  task automatic test_load_pc;
    logic s, c, dn;
    logic [3:0] d;
    logic [3:0] exp_d [6];
    exp_d[0] = 4'h4; exp_d[1] = 4'h5; exp_d[2] = 4'h4; exp_d[3] = 4'h3; exp_d[4] = 4'h2; exp_d[5] = 4'h1;
    i_address = 20'h12345;
    i_cmd_load_pc = 1'b1;
    bus_cycle(s, c, d, dn);
    checks++;
    if (o_stall_alu !== 1'b1) begin
      errors++;
      $display("FAIL load_pc_stall_on: stall=%b required 1", o_stall_alu);
    end
    for (int i = 0; i < 6; i++) begin
      bus_cycle(s, c, d, dn);
      checks++;
      if ({s, c, d, dn, o_stall_alu} !== {1'b1, (i == 0), exp_d[i], (i == 5), 1'b1}) begin
        errors++;
        $display("FAIL load_pc_seq[%0d]: stb=%b cd=%b data=%h done=%b stall=%b required 1 %b %h %b 1",
                 i, s, c, d, dn, o_stall_alu, (i == 0), exp_d[i], (i == 5));
      end
    end
    i_cmd_load_pc = 1'b0;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d, dn, o_stall_alu} !== {1'b1, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_pc_resume: stb=%b cd=%b data=%h done=%b stall=%b required 1 1 0 0 0", s, c, d, dn, o_stall_alu);
    end
  endtask

  task automatic test_dp_write(input logic [3:0] cnt);
    logic s, c, dn;
    logic [3:0] d;
    i_xfr_cnt = cnt;
    i_cmd_dp_write = 1'b1;
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d} !== {1'b1, 1'b1, 4'h3}) begin
      errors++;
      $display("FAIL dp_write_cmd: stb=%b cd=%b data=%h required 1 1 3", s, c, d);
    end
    for (int i = 0; i <= int'(cnt); i++) begin
      i_nibble = o_data_ptr + 4'd8;
      checks++;
      if (o_data_ptr !== 4'(i)) begin
        errors++;
        $display("FAIL dp_write_ptr[%0d]: ptr=%h required %h", i, o_data_ptr, 4'(i));
      end
      bus_cycle(s, c, d, dn);
      checks++;
      if ({s, c, d, dn} !== {1'b1, 1'b0, 4'(8 + i), (i == int'(cnt))}) begin
        errors++;
        $display("FAIL dp_write_data[%0d]: stb=%b cd=%b data=%h done=%b required 1 0 %h %b",
                 i, s, c, d, dn, 4'(8 + i), (i == int'(cnt)));
      end
    end
    i_cmd_dp_write = 1'b0;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d, o_stall_alu} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL dp_write_resume: stb=%b cd=%b data=%h stall=%b required 1 1 0 0", s, c, d, o_stall_alu);
    end
  endtask

  task automatic test_alu_busy;
    logic s, c, dn;
    logic [3:0] d;
    i_bus_data = 4'h9;
    bus_cycle(s, c, d, dn);
    i_alu_busy = 1'b1;
    i_bus_data = 4'h5;
    for (int i = 0; i < 3; i++) begin
      bus_cycle(s, c, d, dn);
      checks++;
      if ({s, o_nibble, o_stall_alu} !== {1'b0, 4'h9, 1'b0}) begin
        errors++;
        $display("FAIL alu_busy[%0d]: stb=%b nib=%h stall=%b required 0 9 0", i, s, o_nibble, o_stall_alu);
      end
    end
    i_alu_busy = 1'b0;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, o_nibble} !== {1'b1, 4'h5}) begin
      errors++;
      $display("FAIL alu_busy_release: stb=%b nib=%h required 1 5", s, o_nibble);
    end
  endtask

  task automatic test_stalled;
    logic s, c, dn;
    logic [3:0] d;
    i_address = 20'hABCDE;
    i_cmd_load_pc = 1'b1;
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, d} !== {1'b1, 4'hD}) begin
      errors++;
      $display("FAIL stall_pre_nib1: stb=%b data=%h required 1 D", s, d);
    end
    tick(2'd0);
    i_stalled = 1'b1;
    #1;
    checks++;
    if ({o_bus_strobe, o_bus_data} !== {1'b0, 4'hC}) begin
      errors++;
      $display("FAIL stall_immediate: stb=%b data=%h required 0 C", o_bus_strobe, o_bus_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick(2'd1);
      checks++;
      if ({o_bus_strobe, o_bus_data, o_bus_cmd_data, o_stall_alu, o_bus_done} !== {1'b0, 4'hC, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_frozen[%0d]: stb=%b data=%h cd=%b stall=%b done=%b required 0 C 0 1 0",
                 i, o_bus_strobe, o_bus_data, o_bus_cmd_data, o_stall_alu, o_bus_done);
      end
    end
    i_stalled = 1'b0;
    tick(2'd1);
    checks++;
    if (o_bus_strobe !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_restrobe: stb=%b required 0", o_bus_strobe);
    end
    tick(2'd2);
    tick(2'd3);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, d, dn} !== {1'b1, 4'hB, 1'b0}) begin
      errors++;
      $display("FAIL stall_nib3: stb=%b data=%h done=%b required 1 B 0", s, d, dn);
    end
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, d, dn} !== {1'b1, 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL stall_nib4: stb=%b data=%h done=%b required 1 A 1", s, d, dn);
    end
    i_cmd_load_pc = 1'b0;
    bus_cycle(s, c, d, dn);
  endtask

  task automatic test_priority;
    logic s, c, dn;
    logic [3:0] d;
    i_address = 20'h00F0A;
    i_cmd_config = 1'b1; i_cmd_load_dp = 1'b1; i_cmd_dp_read = 1'b1;
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({c, d} !== {1'b1, 4'h6}) begin
      errors++;
      $display("FAIL priority_config: cd=%b data=%h required 1 6", c, d);
    end
    for (int i = 0; i < 5; i++) bus_cycle(s, c, d, dn);
    checks++;
    if (dn !== 1'b1) begin
      errors++;
      $display("FAIL config_done: done=%b required 1", dn);
    end
    i_cmd_config = 1'b0; i_cmd_load_dp = 1'b0; i_cmd_dp_read = 1'b0;
    bus_cycle(s, c, d, dn);
    i_cmd_reset = 1'b1; i_cmd_load_pc = 1'b1;
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d, dn} !== {1'b1, 1'b1, 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL reset_cmd: stb=%b cd=%b data=%h done=%b required 1 1 A 1", s, c, d, dn);
    end
    i_cmd_reset = 1'b0; i_cmd_load_pc = 1'b0;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({c, d, o_stall_alu} !== {1'b1, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_cmd_resume: cd=%b data=%h stall=%b required 1 0 0", c, d, o_stall_alu);
    end
  endtask

  task automatic test_dp_read_abort;
    logic s, c, dn;
    logic [3:0] d;
    logic [3:0] rd [2];
    rd[0] = 4'h7; rd[1] = 4'h2;
    i_xfr_cnt = 4'd5;
    i_cmd_dp_read = 1'b1;
    bus_cycle(s, c, d, dn);
    bus_cycle(s, c, d, dn);
    checks++;
    if ({c, d} !== {1'b1, 4'h1}) begin
      errors++;
      $display("FAIL dp_read_cmd: cd=%b data=%h required 1 1", c, d);
    end
    for (int i = 0; i < 2; i++) begin
      i_bus_data = rd[i];
      bus_cycle(s, c, d, dn);
      checks++;
      if ({s, c, o_nibble, dn} !== {1'b1, 1'b0, rd[i], 1'b0}) begin
        errors++;
        $display("FAIL dp_read_nib[%0d]: stb=%b cd=%b nib=%h done=%b required 1 0 %h 0", i, s, c, o_nibble, dn, rd[i]);
      end
    end
    tick(2'd0);
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_bus_reset, o_bus_strobe, o_stall_alu, o_data_ptr, o_nibble} !== {1'b1, 1'b0, 1'b1, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL async_abort: rst=%b stb=%b stall=%b ptr=%h nib=%h required 1 0 1 0 0",
               o_bus_reset, o_bus_strobe, o_stall_alu, o_data_ptr, o_nibble);
    end
    i_cmd_dp_read = 1'b0;
    i_reset = 1'b1;
    bus_cycle(s, c, d, dn);
    checks++;
    if ({s, c, d, o_bus_reset} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL abort_resume: stb=%b cd=%b data=%h rst=%b required 1 1 0 0", s, c, d, o_bus_reset);
    end
  endtask

  initial begin
    test_reset();
    test_load_pc();
    test_dp_write(4'd3);
    test_dp_write(4'd0);
    test_alu_busy();
    test_stalled();
    test_priority();
    test_dp_read_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
